hcms_serial_rx: RTL and testbench

//  Display-side receiver for the HCMS-29xx 4-wire serial link (SER_DATA/SER_CLK/RSEL/nCE/nRESET).

---
 rtl/hcms_pkg.sv | 26 ++
 rtl/hcms_sync_edge.sv | 34 +++
 rtl/hcms_serial_rx.sv | 190 +++++++++++++++++++
 tb/tb_hcms_serial_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcms_pkg.sv
// hcms_pkg
// Shared definitions for the HCMS-29xx serial link receiver:
// control-word bit positions, default dot-frame length and FSM states.
package hcms_pkg;

    // Control word select: 0 = word 0 (brightness/peak/sleep), 1 = word 1
    localparam int unsigned CW_SEL       = 7;
    // Control word 0 fields
    localparam int unsigned CW_SLEEP     = 6;
    localparam int unsigned CW_PEAK_HI   = 5;
    localparam int unsigned CW_PEAK_LO   = 4;
    localparam int unsigned CW_BRIGHT_HI = 3;
    localparam int unsigned CW_BRIGHT_LO = 0;
    // Control word 1 fields
    localparam int unsigned CW_DOUT      = 0;
    localparam int unsigned CW_PRESCALE  = 1;

    // 4 characters x 5 columns
    localparam int unsigned DOT_BYTES_DEF = 20;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/hcms_sync_edge.sv
// hcms_sync_edge
// N-stage synchroniser for one asynchronous link input, with rise/fall
// detection on the synchronised copy.
// Ports:
//   clk      in   system clock
//   i_async  in   asynchronous input
//   o_level  out  synchronised level
//   o_rise   out  1 when the synchronised level has just gone 0->1
//   o_fall   out  1 when the synchronised level has just gone 1->0
// The chain is deliberately not reset: it keeps tracking the pins during
// reset so that no artificial edge appears when reset is released.
module hcms_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        r_sync <= {r_sync[STAGES-2:0], i_async};
        r_prev <= r_sync[STAGES-1];
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/hcms_serial_rx.sv
// hcms_serial_rx
// Display-side receiver for the HCMS-29xx 4-wire serial link. Oversamples
// the link, deserialises MSB-first bytes, strobes each byte, counts dot
// bytes and applies control words at the end of RSEL=1 frames.
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   ser_data_i, ser_clk_i       link data / clock (clock idles high)
//   rsel_i, nce_i, nreset_i     register select, frame enable, display reset
//   byte_o, byte_valid_o        last byte and its 1-cycle strobe
//   byte_rsel_o                 RSEL captured with the byte's 8th bit
//   dot_count_o                 dot bytes in current/last frame (saturating)
//   frame_done_o, frame_err_o   end-of-frame strobes (clean / partial byte)
//   bright_o .. prescale_o      control register contents
module hcms_serial_rx
    import hcms_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DOT_BYTES   = DOT_BYTES_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ser_data_i,
    input  logic                             ser_clk_i,
    input  logic                             rsel_i,
    input  logic                             nce_i,
    input  logic                             nreset_i,
    output logic [7:0]                       byte_o,
    output logic                             byte_valid_o,
    output logic                             byte_rsel_o,
    output logic [$clog2(DOT_BYTES+1)-1:0]   dot_count_o,
    output logic                             frame_done_o,
    output logic                             frame_err_o,
    output logic [3:0]                       bright_o,
    output logic [1:0]                       peak_o,
    output logic                             sleep_n_o,
    output logic                             dout_ctl_o,
    output logic                             prescale_o
);

    localparam int unsigned DCW = $clog2(DOT_BYTES+1);
    localparam logic [DCW-1:0] DOT_MAX = DCW'(DOT_BYTES);

    // Synchronised link inputs
    logic w_data_s, w_data_rise, w_data_fall;
    logic w_clk_s,  w_clk_rise,  w_clk_fall;
    logic w_rsel_s, w_rsel_rise, w_rsel_fall;
    logic w_nce_s,  w_nce_rise,  w_nce_fall;
    logic w_nrst_s, w_nrst_rise, w_nrst_fall;
    logic w_unused_edges;

    hcms_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .i_async(ser_data_i),
        .o_level(w_data_s), .o_rise(w_data_rise), .o_fall(w_data_fall));
    hcms_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .i_async(ser_clk_i),
        .o_level(w_clk_s), .o_rise(w_clk_rise), .o_fall(w_clk_fall));
    hcms_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rsel (
        .clk(clk), .i_async(rsel_i),
        .o_level(w_rsel_s), .o_rise(w_rsel_rise), .o_fall(w_rsel_fall));
    hcms_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_nce (
        .clk(clk), .i_async(nce_i),
        .o_level(w_nce_s), .o_rise(w_nce_rise), .o_fall(w_nce_fall));
    hcms_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_nrst (
        .clk(clk), .i_async(nreset_i),
        .o_level(w_nrst_s), .o_rise(w_nrst_rise), .o_fall(w_nrst_fall));

    assign w_unused_edges = ^{w_data_rise, w_data_fall, w_clk_s, w_clk_fall,
                              w_rsel_rise, w_rsel_fall, w_nce_s,
                              w_nrst_rise, w_nrst_fall};

    // Registered state and outputs
    rx_state_t      r_state;
    logic [6:0]     r_shreg;
    logic [2:0]     r_bitcnt;
    logic           r_have_byte;
    logic [7:0]     r_byte;
    logic           r_byte_valid;
    logic           r_byte_rsel;
    logic [DCW-1:0] r_dot_count;
    logic           r_frame_done;
    logic           r_frame_err;
    logic [3:0]     r_bright;
    logic [1:0]     r_peak;
    logic           r_sleep_n;
    logic           r_dout_ctl;
    logic           r_prescale;

    logic       w_rst;
    logic       w_shift_en;
    logic       w_byte_done;
    logic [7:0] w_new_byte;
    logic [2:0] w_bitcnt_nx;
    logic       w_have_nx;
    logic [7:0] w_last_byte;
    logic       w_last_rsel;

    assign w_rst = reset | ~w_nrst_s;

    // A SER_CLK rise in the same cycle as the nCE rise is folded in first,
    // so frame-end decisions look at the post-shift bit count and byte.
    always_comb begin
        w_shift_en  = (r_state == ST_SHIFT) && w_clk_rise;
        w_byte_done = w_shift_en && (r_bitcnt == 3'd7);
        w_new_byte  = {r_shreg, w_data_s};
        w_bitcnt_nx = w_shift_en ? r_bitcnt + 3'd1 : r_bitcnt;
        w_have_nx   = r_have_byte | w_byte_done;
        w_last_byte = w_byte_done ? w_new_byte : r_byte;
        w_last_rsel = w_byte_done ? w_rsel_s   : r_byte_rsel;
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_have_byte  <= 1'b0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_byte_rsel  <= 1'b0;
            r_dot_count  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_bright     <= '0;
            r_peak       <= '0;
            r_sleep_n    <= 1'b0;
            r_dout_ctl   <= 1'b0;
            r_prescale   <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_nce_fall) begin
                        r_state     <= ST_SHIFT;
                        r_bitcnt    <= '0;
                        r_dot_count <= '0;
                        r_have_byte <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_shift_en) begin
                        r_shreg  <= w_new_byte[6:0];
                        r_bitcnt <= w_bitcnt_nx;
                    end
                    if (w_byte_done) begin
                        r_byte       <= w_new_byte;
                        r_byte_valid <= 1'b1;
                        r_byte_rsel  <= w_rsel_s;
                        r_have_byte  <= 1'b1;
                        if (!w_rsel_s && (r_dot_count != DOT_MAX))
                            r_dot_count <= r_dot_count + 1'b1;
                    end
                    if (w_nce_rise) begin
                        r_state <= ST_IDLE;
                        if (w_bitcnt_nx != 3'd0) begin
                            r_frame_err <= 1'b1;
                        end else if (w_have_nx) begin
                            r_frame_done <= 1'b1;
                            if (w_last_rsel) begin
                                if (w_last_byte[CW_SEL]) begin
                                    r_dout_ctl <= w_last_byte[CW_DOUT];
                                    r_prescale <= w_last_byte[CW_PRESCALE];
                                end else begin
                                    r_bright  <= w_last_byte[CW_BRIGHT_HI:CW_BRIGHT_LO];
                                    r_peak    <= w_last_byte[CW_PEAK_HI:CW_PEAK_LO];
                                    r_sleep_n <= w_last_byte[CW_SLEEP];
                                end
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byte_o       = r_byte;
    assign byte_valid_o = r_byte_valid;
    assign byte_rsel_o  = r_byte_rsel;
    assign dot_count_o  = r_dot_count;
    assign frame_done_o = r_frame_done;
    assign frame_err_o  = r_frame_err;
    assign bright_o     = r_bright;
    assign peak_o       = r_peak;
    assign sleep_n_o    = r_sleep_n;
    assign dout_ctl_o   = r_dout_ctl;
    assign prescale_o   = r_prescale;

endmodule

// File: tb/tb_hcms_serial_rx.sv
// tb_hcms_serial_rx
// Drives HCMS link frames (SER_CLK = clk/8) and compares strobed bytes,
// frame strobes, dot count and control registers against a frame-level
// model of the link protocol.
module tb_hcms_serial_rx;

    localparam int unsigned DOT = 20;
    localparam int unsigned LAT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_data_i, ser_clk_i, rsel_i, nce_i, nreset_i;
    logic [7:0] byte_o;
    logic       byte_valid_o, byte_rsel_o;
    logic [4:0] dot_count_o;
    logic       frame_done_o, frame_err_o;
    logic [3:0] bright_o;
    logic [1:0] peak_o;
    logic       sleep_n_o, dout_ctl_o, prescale_o;

    hcms_serial_rx #(.SYNC_STAGES(2), .DOT_BYTES(DOT)) dut (
        .clk(clk), .reset(reset),
        .ser_data_i(ser_data_i), .ser_clk_i(ser_clk_i), .rsel_i(rsel_i),
        .nce_i(nce_i), .nreset_i(nreset_i),
        .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_rsel_o(byte_rsel_o),
        .dot_count_o(dot_count_o), .frame_done_o(frame_done_o),
        .frame_err_o(frame_err_o), .bright_o(bright_o), .peak_o(peak_o),
        .sleep_n_o(sleep_n_o), .dout_ctl_o(dout_ctl_o), .prescale_o(prescale_o));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor
    longint     cyc = 0;
    longint     rise_cyc = 0;
    longint     last_lat = 0;
    logic [7:0] obs_b[$];
    logic       obs_r[$];
    int         n_done = 0;
    int         n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid_o) begin
            obs_b.push_back(byte_o);
            obs_r.push_back(byte_rsel_o);
            last_lat = cyc - rise_cyc;
        end
        if (frame_done_o) n_done++;
        if (frame_err_o)  n_err++;
    end

    // Model of the control registers
    logic [3:0] m_bright;
    logic [1:0] m_peak;
    logic       m_sleep, m_dout, m_pre;

    // Frame to send
    logic [7:0]  tx_b[$];
    logic        tx_r[$];
    int unsigned tx_part_n;
    logic [7:0]  tx_part;
    bit          tx_same_edge;

    function automatic logic [31:0] outs_vec();
        return 32'({byte_o, byte_valid_o, byte_rsel_o, dot_count_o, frame_done_o,
                    frame_err_o, bright_o, peak_o, sleep_n_o, dout_ctl_o, prescale_o});
    endfunction

    task automatic send_bit(input logic b, input bit end_frame);
        @(negedge clk);
        ser_clk_i  = 1'b0;
        ser_data_i = b;
        repeat (3) @(negedge clk);
        ser_clk_i = 1'b1;
        rise_cyc  = cyc;
        if (end_frame) nce_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_tx();
        tx_b.delete();
        tx_r.delete();
        tx_part_n    = 0;
        tx_part      = 8'h00;
        tx_same_edge = 1'b0;
    endtask

    task automatic run_frame(input string name);
        int          d0, e0, nb, dots;
        logic [7:0]  lb;
        bit          exp_done;
        d0 = n_done;
        e0 = n_err;
        nb = tx_b.size();
        obs_b.delete();
        obs_r.delete();
        @(negedge clk);
        nce_i = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rsel_i = tx_r[i];
            for (int k = 7; k >= 0; k--)
                send_bit(tx_b[i][k], tx_same_edge && (i == nb - 1) && (k == 0));
        end
        for (int k = 0; k < int'(tx_part_n); k++)
            send_bit(tx_part[7-k], 1'b0);
        if (!(tx_same_edge && nb > 0)) begin
            repeat (4) @(negedge clk);
            nce_i = 1'b1;
        end
        repeat (10) @(negedge clk);

        // Expected behaviour of one frame
        check_eq({name, ":nstrobe"}, obs_b.size(), nb);
        for (int i = 0; i < nb && i < obs_b.size(); i++) begin
            check_eq({name, ":byte"}, obs_b[i], tx_b[i]);
            check_eq({name, ":rsel"}, obs_r[i], tx_r[i]);
        end
        if (nb > 0) check_eq({name, ":latency"}, last_lat, LAT);
        exp_done = (tx_part_n == 0) && (nb > 0);
        check_eq({name, ":done"}, n_done - d0, exp_done ? 1 : 0);
        check_eq({name, ":err"},  n_err - e0, (tx_part_n != 0) ? 1 : 0);
        dots = 0;
        foreach (tx_r[i]) if (!tx_r[i]) dots++;
        check_eq({name, ":dotcnt"}, dot_count_o, (dots > int'(DOT)) ? DOT : dots);
        if (exp_done && tx_r[nb-1]) begin
            lb = tx_b[nb-1];
            if (lb[7]) begin
                m_dout = lb[0];
                m_pre  = lb[1];
            end else begin
                m_bright = lb[3:0];
                m_peak   = lb[5:4];
                m_sleep  = lb[6];
            end
        end
        check_eq({name, ":ctl"}, {bright_o, peak_o, sleep_n_o, dout_ctl_o, prescale_o},
                 {m_bright, m_peak, m_sleep, m_dout, m_pre});
    endtask

    task automatic model_reset();
        m_bright = '0;
        m_peak   = '0;
        m_sleep  = 1'b0;
        m_dout   = 1'b0;
        m_pre    = 1'b0;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        reset = 1'b1; ser_data_i = 1'b0; ser_clk_i = 1'b1; rsel_i = 1'b0;
        nce_i = 1'b1; nreset_i = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check_eq("reset_outs", outs_vec(), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single dot byte
        clear_tx(); tx_b.push_back(8'hA5); tx_r.push_back(1'b0);
        run_frame("dot_a5");

        // Control word 0 then control word 1
        clear_tx(); tx_b.push_back(8'h4F); tx_r.push_back(1'b1);
        run_frame("cw0_4f");
        clear_tx(); tx_b.push_back(8'h83); tx_r.push_back(1'b1);
        run_frame("cw1_83");

        // Partial byte in a control frame
        clear_tx(); tx_r.push_back(1'b1); tx_r.delete();
        rsel_i = 1'b1; tx_part_n = 5; tx_part = 8'hFF;
        run_frame("partial5");

        // Over-length dot frame
        clear_tx();
        for (int i = 0; i < 22; i++) begin
            tx_b.push_back(8'($urandom)); tx_r.push_back(1'b0);
        end
        run_frame("dot22");

        // Last SER_CLK rise coincides with nCE rise
        clear_tx(); tx_b.push_back(8'h35); tx_r.push_back(1'b1);
        tx_same_edge = 1'b1;
        run_frame("same_edge");

        // Display reset mid-byte
        d0 = n_done; e0 = n_err; obs_b.delete();
        @(negedge clk); rsel_i = 1'b1; nce_i = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
        nreset_i = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("nreset_outs", outs_vec(), 0);
        nce_i = 1'b1;
        repeat (4) @(negedge clk);
        nreset_i = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("nreset_strobes", obs_b.size() + (n_done - d0) + (n_err - e0), 0);
        model_reset();
        clear_tx(); tx_b.push_back(8'h3C); tx_r.push_back(1'b0);
        run_frame("after_nreset");

        // Synchronous reset mid-frame, then traffic with nCE still low
        clear_tx(); tx_b.push_back(8'h6A); tx_r.push_back(1'b1);
        run_frame("pre_reset_cw");
        d0 = n_done; e0 = n_err; obs_b.delete();
        @(negedge clk); rsel_i = 1'b0; nce_i = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset_mid_outs", outs_vec(), 0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) send_bit(k[0], 1'b0);
        nce_i = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("ignored_outs", outs_vec(), 0);
        check_eq("ignored_strobes", obs_b.size() + (n_done - d0) + (n_err - e0), 0);
        model_reset();

        // Random frames
        for (int f = 0; f < 25; f++) begin
            int unsigned nb;
            clear_tx();
            nb = $urandom_range(0, 4);
            for (int unsigned i = 0; i < nb; i++) begin
                tx_b.push_back(8'($urandom));
                tx_r.push_back(1'($urandom));
            end
            if ($urandom_range(0, 3) == 0) begin
                tx_part_n = $urandom_range(1, 7);
                tx_part   = 8'($urandom);
            end
            rsel_i = 1'($urandom);
            run_frame($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
